// File: rtl/hpm_counter_unit.sv
// Machine/user performance counter CSR block: mcycle, minstret, programmable event counters,
// their event selectors, mcountinhibit and mcounteren, with registered single-cycle CSR reads.
module hpm_counter_unit #(
  parameter int NUM_HPM       = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16,
  parameter int RETIRE_WIDTH  = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [1:0]                        priv_mode,
  input  logic                              csr_rden,
  input  logic [11:0]                       csr_raddr,
  input  logic                              csr_wren,
  input  logic [11:0]                       csr_waddr,
  input  logic [31:0]                       csr_wdata,
  output logic [31:0]                       csr_rdata,
  output logic                              csr_hit,
  output logic                              csr_illegal,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] instret_inc,
  input  logic [NUM_EVENTS-1:0]             event_in,
  output logic [NUM_HPM+2:0]                counter_ovf
);

  localparam int NUM_CNT = NUM_HPM + 3;
  localparam int EVW     = $clog2(NUM_EVENTS + 1);
  localparam int IW      = $clog2(RETIRE_WIDTH + 1);
  localparam logic [4:0] LAST_IDX = 5'(NUM_HPM + 2);
  // Writable counter-control bits: every counter index except time (bit 1)
  localparam logic [NUM_CNT-1:0] IMPL_MASK = {{(NUM_CNT-2){1'b1}}, 1'b0, 1'b1};

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_MCNT  = 3'd1,
    K_UCNT  = 3'd2,
    K_INH   = 3'd3,
    K_EN    = 3'd4,
    K_EVENT = 3'd5,
    K_BAD   = 3'd6
  } csr_kind_e;

  logic [COUNTER_WIDTH-1:0] cnt_r [NUM_CNT];
  logic [EVW-1:0]           sel_r [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf_r;
  logic [NUM_CNT-1:0]       inhibit_r;
  logic [NUM_CNT-1:0]       counteren_r;
  logic [31:0]              rdata_r;
  logic                     hit_r;
  logic                     ill_r;

  csr_kind_e                rkind_s;
  csr_kind_e                wkind_s;
  logic [4:0]               ridx_s;
  logic [4:0]               widx_s;
  logic                     m_mode_s;
  logic                     rok_s;
  logic                     wok_s;
  logic                     wr_cnt_s;
  logic [31:0]              en32_s;
  logic [31:0]              rval_s;
  logic [COUNTER_WIDTH-1:0] cnt_nx_s [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf_nx_s;

  function automatic csr_kind_e decode(input logic [11:0] a);
    csr_kind_e k;
    if (a == 12'h306) k = K_EN;
    else if (a == 12'h320) k = K_INH;
    else if (a[11:5] == 7'h19) k = K_EVENT;
    else if (a[11:5] == 7'h58 || a[11:5] == 7'h5C) k = K_MCNT;
    else if (a[11:5] == 7'h60 || a[11:5] == 7'h64) k = K_UCNT;
    else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[7:0] < 8'hA0) k = K_BAD;
    else k = K_NONE;
    return k;
  endfunction

  function automatic logic access_ok(input csr_kind_e k, input logic [4:0] idx, input logic wr,
                                     input logic m_mode, input logic [31:0] en);
    logic cnt_ok;
    logic ok;
    cnt_ok = (idx != 5'd1) && (idx <= LAST_IDX);
    case (k)
      K_MCNT:       ok = m_mode && cnt_ok;
      K_UCNT:       ok = !wr && cnt_ok && (m_mode || en[idx]);
      K_INH, K_EN:  ok = m_mode;
      K_EVENT:      ok = m_mode && (idx >= 5'd3) && (idx <= LAST_IDX);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Address decode and legality of both ports
  always_comb begin
    m_mode_s = (priv_mode == 2'b11);
    rkind_s  = decode(csr_raddr);
    wkind_s  = decode(csr_waddr);
    ridx_s   = csr_raddr[4:0];
    widx_s   = csr_waddr[4:0];
    en32_s   = 32'(counteren_r);
    rok_s    = access_ok(rkind_s, ridx_s, 1'b0, m_mode_s, en32_s);
    wok_s    = access_ok(wkind_s, widx_s, 1'b1, m_mode_s, en32_s);
    wr_cnt_s = csr_wren && (wkind_s == K_MCNT) && wok_s;
  end

  // Next counter values: a CSR write beats the increment and clears the wrap flag
  always_comb begin
    logic [63:0]              ext;
    logic [63:0]              merged;
    logic [COUNTER_WIDTH:0]   inc;
    logic [COUNTER_WIDTH:0]   sum;
    ovf_nx_s = {NUM_CNT{1'b0}};
    for (int i = 0; i < NUM_CNT; i++) begin
      ext = 64'd0;
      ext[COUNTER_WIDTH-1:0] = cnt_r[i];
      inc = {(COUNTER_WIDTH+1){1'b0}};
      if (i == 0) begin
        inc[0] = 1'b1;
      end else if (i == 2) begin
        inc[IW-1:0] = instret_inc;
      end else if (i >= 3) begin
        for (int e = 0; e < NUM_EVENTS; e++) begin
          inc[0] = inc[0] | ((sel_r[i] == EVW'(e + 1)) & event_in[e]);
        end
      end else begin
        inc[0] = 1'b0;
      end
      sum    = {1'b0, cnt_r[i]} + inc;
      merged = csr_waddr[7] ? {csr_wdata, ext[31:0]} : {ext[63:32], csr_wdata};
      if (i == 1) begin
        cnt_nx_s[i] = {COUNTER_WIDTH{1'b0}};
        ovf_nx_s[i] = 1'b0;
      end else if (wr_cnt_s && widx_s == 5'(i)) begin
        cnt_nx_s[i] = merged[COUNTER_WIDTH-1:0];
        ovf_nx_s[i] = 1'b0;
      end else if (!inhibit_r[i]) begin
        cnt_nx_s[i] = sum[COUNTER_WIDTH-1:0];
        ovf_nx_s[i] = ovf_r[i] | sum[COUNTER_WIDTH];
      end else begin
        cnt_nx_s[i] = cnt_r[i];
        ovf_nx_s[i] = ovf_r[i];
      end
    end
  end

  // Read mux over the current (pre-write) state
  always_comb begin
    logic [63:0] ext;
    ext    = 64'd0;
    rval_s = 32'd0;
    case (rkind_s)
      K_MCNT, K_UCNT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          ext[COUNTER_WIDTH-1:0] = (ridx_s == 5'(i)) ? cnt_r[i] : ext[COUNTER_WIDTH-1:0];
        end
        rval_s = csr_raddr[7] ? ext[63:32] : ext[31:0];
      end
      K_INH: rval_s = 32'(inhibit_r);
      K_EN:  rval_s = en32_s;
      K_EVENT: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          rval_s = (ridx_s == 5'(i)) ? 32'(sel_r[i]) : rval_s;
        end
      end
      default: rval_s = 32'd0;
    endcase
  end

  // State and registered CSR response
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= {COUNTER_WIDTH{1'b0}};
        sel_r[i] <= {EVW{1'b0}};
      end
      ovf_r       <= {NUM_CNT{1'b0}};
      inhibit_r   <= {NUM_CNT{1'b0}};
      counteren_r <= {NUM_CNT{1'b0}};
      rdata_r     <= 32'd0;
      hit_r       <= 1'b0;
      ill_r       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= cnt_nx_s[i];
        if (csr_wren && wkind_s == K_EVENT && wok_s && widx_s == 5'(i)) begin
          sel_r[i] <= csr_wdata[EVW-1:0];
        end
      end
      ovf_r <= ovf_nx_s;
      if (csr_wren && wkind_s == K_INH && wok_s) begin
        inhibit_r <= csr_wdata[NUM_CNT-1:0] & IMPL_MASK;
      end
      if (csr_wren && wkind_s == K_EN && wok_s) begin
        counteren_r <= csr_wdata[NUM_CNT-1:0] & IMPL_MASK;
      end
      rdata_r <= (csr_rden && rkind_s != K_NONE && rok_s) ? rval_s : 32'd0;
      hit_r   <= (csr_rden && rkind_s != K_NONE) || (csr_wren && wkind_s != K_NONE);
      ill_r   <= (csr_rden && rkind_s != K_NONE && !rok_s) ||
                 (csr_wren && wkind_s != K_NONE && !wok_s);
    end
  end

  assign csr_rdata   = rdata_r;
  assign csr_hit     = hit_r;
  assign csr_illegal = ill_r;
  assign counter_ovf = ovf_r;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Bench for hpm_counter_unit: a cycle-level model of the counter CSRs checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hpm_counter_unit;
  localparam int NH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  priv_mode = 2'b11;
  logic        csr_rden = 1'b0;
  logic [11:0] csr_raddr = 12'h000;
  logic        csr_wren = 1'b0;
  logic [11:0] csr_waddr = 12'h000;
  logic [31:0] csr_wdata = 32'd0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        csr_illegal;
  logic [1:0]  instret_inc = 2'd0;
  logic [15:0] event_in = 16'h0000;
  logic [6:0]  counter_ovf;

  int total = 0;
  int bad = 0;

  logic [63:0] m_cnt [7];
  int          m_sel [7];
  logic [6:0]  m_ovf = 7'd0;
  logic [31:0] m_inh = 32'd0;
  logic [31:0] m_en = 32'd0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_hit = 1'b0;
  logic        exp_ill = 1'b0;

  always #5 clock = ~clock;

  hpm_counter_unit #(.NUM_HPM(NH), .COUNTER_WIDTH(64), .NUM_EVENTS(16), .RETIRE_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .priv_mode(priv_mode),
    .csr_rden(csr_rden), .csr_raddr(csr_raddr),
    .csr_wren(csr_wren), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_hit(csr_hit), .csr_illegal(csr_illegal),
    .instret_inc(instret_inc), .event_in(event_in), .counter_ovf(counter_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Ownership and legality straight from the address map rules
  function automatic void classify(input logic [11:0] a, input bit wr, output bit owned, output bit ok);
    int idx;
    bit m;
    bit cnt_ok;
    idx    = int'(a[4:0]);
    m      = (priv_mode == 2'b11);
    cnt_ok = (idx == 0) || (idx >= 2 && idx <= NH + 2);
    owned  = 1'b0;
    ok     = 1'b0;
    if (a == 12'h306 || a == 12'h320) begin
      owned = 1'b1; ok = m;
    end else if (a > 12'h320 && a <= 12'h33F) begin
      owned = 1'b1; ok = m && idx >= 3 && idx <= NH + 2;
    end else if (a >= 12'hB00 && a <= 12'hB9F) begin
      owned = 1'b1; ok = m && cnt_ok && (a <= 12'hB1F || a >= 12'hB80);
    end else if (a >= 12'hC00 && a <= 12'hC9F) begin
      owned = 1'b1; ok = !wr && cnt_ok && (a <= 12'hC1F || a >= 12'hC80) && (m || m_en[idx]);
    end
  endfunction

  function automatic logic [31:0] mval(input logic [11:0] a);
    int idx;
    idx = int'(a[4:0]);
    if (a == 12'h306) return m_en;
    if (a == 12'h320) return m_inh;
    if (a[11:8] == 4'h3) return 32'(m_sel[idx]);
    return a[7] ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit ro, rk, wo, wk;
    int idx;
    int inc;
    logic [63:0] old;
    if (!reset) begin
      for (int i = 0; i < 7; i++) begin m_cnt[i] = 64'd0; m_sel[i] = 0; end
      m_ovf = 7'd0; m_inh = 32'd0; m_en = 32'd0;
      exp_rdata = 32'd0; exp_hit = 1'b0; exp_ill = 1'b0;
      return;
    end
    classify(csr_raddr, 1'b0, ro, rk);
    classify(csr_waddr, 1'b1, wo, wk);
    exp_hit   = (csr_rden && ro) || (csr_wren && wo);
    exp_ill   = (csr_rden && ro && !rk) || (csr_wren && wo && !wk);
    exp_rdata = (csr_rden && ro && rk) ? mval(csr_raddr) : 32'd0;
    idx = int'(csr_waddr[4:0]);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) continue;
      if (csr_wren && wk && csr_waddr[11:8] == 4'hB && idx == i) begin
        if (csr_waddr[7]) m_cnt[i][63:32] = csr_wdata;
        else m_cnt[i][31:0] = csr_wdata;
        m_ovf[i] = 1'b0;
      end else if (!m_inh[i]) begin
        if (i == 0) inc = 1;
        else if (i == 2) inc = int'(instret_inc);
        else inc = (m_sel[i] >= 1 && m_sel[i] <= 16) ? int'(event_in[m_sel[i] - 1]) : 0;
        old = m_cnt[i];
        m_cnt[i] = m_cnt[i] + 64'(inc);
        if (m_cnt[i] < old) m_ovf[i] = 1'b1;
      end
    end
    if (csr_wren && wk) begin
      if (csr_waddr == 12'h320) m_inh = csr_wdata & 32'h7D;
      else if (csr_waddr == 12'h306) m_en = csr_wdata & 32'h7D;
      else if (csr_waddr[11:8] == 4'h3) m_sel[idx] = int'(csr_wdata & 32'h1F);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    chk("rdata", csr_rdata, exp_rdata);
    chk("hit", csr_hit, exp_hit);
    chk("illegal", csr_illegal, exp_ill);
    chk("ovf", counter_ovf, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wren = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_wren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_rden = 1'b1; csr_raddr = a;
    tick();
    csr_rden = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [11:0] a, input logic [31:0] v);
    rd(a);
    chk(name, csr_rdata, v);
  endtask

  initial begin
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    rd_expect("rst_B00", 12'hB00, 32'h0);
    rd_expect("rst_B02", 12'hB02, 32'h0);
    rd_expect("rst_B03", 12'hB03, 32'h0);
    rd_expect("rst_323", 12'h323, 32'h0);
    rd_expect("rst_320", 12'h320, 32'h0);
    rd_expect("rst_306", 12'h306, 32'h0);
    chk("rst_ovf", counter_ovf, 7'h00);

    // mcycle wrap
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'hFFFF_FFFF);
    idle(1);
    chk("wrap_ovf0_early", counter_ovf[0], 1'b0);
    idle(1);
    chk("wrap_ovf0", counter_ovf[0], 1'b1);
    idle(1);
    rd_expect("wrap_B00", 12'hB00, 32'h1);
    rd_expect("wrap_B80", 12'hB80, 32'h0);

    // event and retire counting
    wr(12'h323, 32'd2);
    for (int k = 0; k < 5; k++) begin
      event_in = 16'h0002;
      instret_inc = (k < 4) ? 2'd2 : 2'd0;
      tick();
    end
    event_in = 16'h0000;
    instret_inc = 2'd0;
    rd_expect("evt_B03", 12'hB03, 32'd5);
    rd_expect("ret_B02", 12'hB02, 32'd8);

    // inhibit mcycle
    wr(12'h320, 32'h1);
    rd_expect("inh_B00_a", 12'hB00, 32'd12);
    idle(10);
    rd_expect("inh_B00_b", 12'hB00, 32'd12);
    wr(12'h320, 32'h0);
    rd_expect("inh_B00_c", 12'hB00, 32'd12);
    rd_expect("inh_B00_d", 12'hB00, 32'd13);

    // user-mode shadow access
    priv_mode = 2'b00;
    rd(12'hC03);
    chk("u_C03_ill", csr_illegal, 1'b1);
    chk("u_C03_data", csr_rdata, 32'h0);
    priv_mode = 2'b11;
    wr(12'h306, 32'h8);
    priv_mode = 2'b00;
    rd(12'hC03);
    chk("u_C03_ok", csr_illegal, 1'b0);
    chk("u_C03_val", csr_rdata, 32'd5);
    rd(12'hB03);
    chk("u_B03_ill", csr_illegal, 1'b1);
    priv_mode = 2'b11;

    // hpm3 wrap, then write colliding with an event pulse
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    event_in = 16'h0002;
    tick();
    chk("hpm3_ovf_set", counter_ovf[3], 1'b1);
    wr(12'hB03, 32'h10);
    event_in = 16'h0000;
    chk("hpm3_ovf_clr", counter_ovf[3], 1'b0);
    rd_expect("hpm3_wr_wins", 12'hB03, 32'h10);
    rd_expect("hpm3_hi_kept", 12'hB83, 32'h0);

    // read and write of the same CSR in one cycle
    csr_rden = 1'b1; csr_raddr = 12'hB02;
    csr_wren = 1'b1; csr_waddr = 12'hB02; csr_wdata = 32'h1234;
    tick();
    csr_rden = 1'b0; csr_wren = 1'b0;
    chk("rw_prewrite", csr_rdata, 32'd8);
    rd_expect("rw_after", 12'hB02, 32'h1234);

    // illegal accesses and hardwired fields
    wr(12'hC03, 32'h5);
    chk("wr_C03_ill", csr_illegal, 1'b1);
    rd_expect("wr_C03_noeff", 12'hB03, 32'h10);
    rd(12'hC01);
    chk("time_ill", csr_illegal, 1'b1);
    rd(12'hB07);
    chk("idx_ill", csr_illegal, 1'b1);
    rd(12'h300);
    chk("unowned_hit", csr_hit, 1'b0);
    wr(12'h324, 32'hFFFF_FFFF);
    rd_expect("sel_mask", 12'h324, 32'h1F);
    event_in = 16'hFFFF;
    idle(2);
    event_in = 16'h0000;
    rd_expect("sel_unimpl", 12'hB04, 32'h0);
    wr(12'h320, 32'hFFFF_FFFF);
    rd_expect("inh_mask", 12'h320, 32'h7D);
    wr(12'h320, 32'h0);

    // reset in the middle of a read
    csr_rden = 1'b1; csr_raddr = 12'hB00;
    reset = 1'b0;
    tick();
    chk("midrst_data", csr_rdata, 32'h0);
    reset = 1'b1;
    csr_rden = 1'b0;
    rd_expect("midrst_B00", 12'hB00, 32'h0);
    chk("midrst_ovf", counter_ovf, 7'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
